// File: rtl/comm_pkg.sv
`default_nettype none
// ============================================================================
// Package  : comm_pkg
// Purpose  : Shared TX state encoding and frame constants for the UART word TX.
// Revision : 1.0  initial release
// ============================================================================
package comm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    localparam int WORDS_PER_FRAME  = 18;
    localparam int DEF_CLKS_PER_BIT = 5;

endpackage
`default_nettype wire

// File: rtl/comm_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : comm_sync_fifo
// Purpose  : Generic synchronous FIFO with first-word-fall-through output.
// Revision : 1.0  initial release
// ============================================================================
module comm_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_wr;
    logic             w_rd;

    // A full FIFO refuses a push even when a pop happens in the same cycle.
    assign w_wr  = push & ~full;
    assign w_rd  = pop & ~empty;
    assign full  = (r_count == (AW+1)'(DEPTH));
    assign empty = (r_count == '0);
    assign dout  = r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr)
            r_mem[r_wr_ptr] <= din;
    end

endmodule
`default_nettype wire

// File: rtl/comm_uart_word_tx.sv
`default_nettype none
// ============================================================================
// Module   : comm_uart_word_tx
// Purpose  : Captures a word per RD pulse, queues it and sends it as one UART
//            character; counts words and flags the end of each frame.
// Revision : 1.0  initial release
// ============================================================================
module comm_uart_word_tx #(
    parameter int CLKS_PER_BIT    = comm_pkg::DEF_CLKS_PER_BIT,
    parameter int PARITY_EN       = 1,
    parameter int FIFO_DEPTH      = 4,
    parameter int WORDS_PER_FRAME = comm_pkg::WORDS_PER_FRAME
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RD,
    input  logic [7:0] dataIn,
    output logic       tx,
    output logic       txBusy,
    output logic       fifoFull,
    output logic       ovf,
    output logic [4:0] wordCnt,
    output logic       frameDone
);

    import comm_pkg::*;

    localparam int BW = $clog2(CLKS_PER_BIT);

    logic       r_rd_dly;
    logic       r_ovf;
    logic       w_push;
    logic       w_pop;
    logic       w_empty;
    logic       w_full;
    logic [7:0] w_dout;
    logic       w_bit_end;

    tx_state_t  r_state;
    logic [BW-1:0] r_baud;
    logic [2:0] r_bit;
    logic [7:0] r_sh;
    logic       r_par;
    logic       r_tx;
    logic [4:0] r_wcnt;
    logic       r_frame_done;

    assign w_push    = RD & ~r_rd_dly;
    assign w_pop     = (r_state == ST_IDLE) & ~w_empty;
    assign w_bit_end = (r_baud == BW'(CLKS_PER_BIT - 1));

    comm_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .din   (dataIn),
        .dout  (w_dout),
        .full  (w_full),
        .empty (w_empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_dly <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_rd_dly <= RD;
            if (w_push && w_full)
                r_ovf <= 1'b1;
        end
    end

    // tx is registered from the current state, so the line trails the FSM by one clk.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_baud       <= '0;
            r_bit        <= '0;
            r_sh         <= '0;
            r_par        <= 1'b0;
            r_tx         <= 1'b1;
            r_wcnt       <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (r_state == ST_IDLE || w_bit_end)
                r_baud <= '0;
            else
                r_baud <= r_baud + 1'b1;

            case (r_state)
                ST_IDLE: begin
                    r_tx <= 1'b1;
                    if (!w_empty) begin
                        r_sh    <= w_dout;
                        r_par   <= 1'b0;
                        r_state <= ST_START;
                    end
                end
                ST_START: begin
                    r_tx <= 1'b0;
                    if (w_bit_end) begin
                        r_bit   <= '0;
                        r_state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    r_tx <= r_sh[0];
                    if (w_bit_end) begin
                        r_par <= r_par ^ r_sh[0];
                        r_sh  <= {1'b0, r_sh[7:1]};
                        if (r_bit == 3'd7)
                            r_state <= (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                        else
                            r_bit <= r_bit + 3'd1;
                    end
                end
                ST_PARITY: begin
                    r_tx <= r_par;
                    if (w_bit_end)
                        r_state <= ST_STOP;
                end
                ST_STOP: begin
                    r_tx <= 1'b1;
                    if (w_bit_end) begin
                        if (r_wcnt == 5'(WORDS_PER_FRAME - 1)) begin
                            r_wcnt       <= '0;
                            r_frame_done <= 1'b1;
                        end else begin
                            r_wcnt <= r_wcnt + 5'd1;
                        end
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign tx        = r_tx;
    assign txBusy    = (r_state != ST_IDLE) | ~w_empty;
    assign fifoFull  = w_full;
    assign ovf       = r_ovf;
    assign wordCnt   = r_wcnt;
    assign frameDone = r_frame_done;

endmodule
`default_nettype wire
